// File: rtl/io_ddr_pkg.sv
// Shared constants and helpers for the DDR input deserializer.
// Optional feature macro: IO_DDR_LSB_FIRST_EN (see io_ddr_deser.sv).
package io_ddr_pkg;

    // Default pad width; the top level builds its own pair width from IO_W.
    localparam int DEF_IO_W = 8;

    // One rising/falling beat pair at the default pad width.
    typedef logic [2*DEF_IO_W-1:0] pair_t;

    // Width of a level counter that must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A word must be made of whole clock periods (two beats each).
    function automatic bit beats_ok(input int beats);
        return (beats >= 2) && ((beats % 2) == 0);
    endfunction

    // Pointers wrap for free only when the depth is a power of two.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/io_ddr_deser_if.sv
// Pad-side and demodulator-side signals of the DDR deserializer.
// Handshake: a word moves when data_valid and data_ready are both high at a
// rising clock edge; data_valid never depends on data_ready, and data_out is
// stable while data_valid is high and the word has not been taken.
interface io_ddr_deser_if
    import io_ddr_pkg::*;
#(
    parameter int IO_W       = 8,
    parameter int BEATS      = 2,
    parameter int FIFO_DEPTH = 4
);
    logic [IO_W-1:0]                io_in;
    logic                           io_valid;
    logic                           sync;
    logic [IO_W*BEATS-1:0]          data_out;
    logic                           data_valid;
    logic                           data_ready;
    logic [level_w(FIFO_DEPTH)-1:0] fifo_level;
    logic                           overflow;
    logic                           clr_ovf;

    // Driver side: pads, consumer and control.
    modport master (
        output io_in, io_valid, sync, data_ready, clr_ovf,
        input  data_out, data_valid, fifo_level, overflow
    );

    // Deserializer side.
    modport slave (
        input  io_in, io_valid, sync, data_ready, clr_ovf,
        output data_out, data_valid, fifo_level, overflow
    );
endinterface

// File: rtl/io_ddr_fifo.sv
// Show-ahead word FIFO: the head word is visible whenever not empty, and the
// last popped word is held on o_data while empty.
module io_ddr_fifo
    import io_ddr_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [W-1:0]              i_data,
    input  logic                      i_pop,
    output logic [W-1:0]              o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [level_w(DEPTH)-1:0] o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_hold;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    // A pop on a full FIFO frees the slot that the same-cycle push uses.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? r_hold : r_mem[r_rd_ptr];

    // Word storage, written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap modulo DEPTH; the level is counted separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/io_ddr_deser.sv
// DDR pad deserializer: captures a beat on each clock edge, assembles BEATS
// beats into a word and queues finished words for the demodulator.
// Optional feature macro: IO_DDR_LSB_FIRST_EN reverses beat order so the
// first beat on the pads lands in the least-significant byte of the word.
module io_ddr_deser
    import io_ddr_pkg::*;
#(
    parameter int IO_W       = 8,
    parameter int BEATS      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    io_ddr_deser_if.slave bus
);
    localparam int PAIRS  = BEATS / 2;
    localparam int PAIR_W = 2 * IO_W;
    localparam int WORD_W = IO_W * BEATS;
    localparam int CNT_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int LW     = level_w(FIFO_DEPTH);

    if (!beats_ok(BEATS)) begin : g_bad_beats
        $error("io_ddr_deser: BEATS must be even and at least 2");
    end
    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("io_ddr_deser: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [IO_W-1:0]   r_rise_q;
    logic [IO_W-1:0]   r_fall_q;
    logic              r_pair_vld;
    logic              r_sync_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_acc;
    logic              r_overflow;

    logic [PAIR_W-1:0] w_pair;
    logic [CNT_W-1:0]  w_cnt_eff;
    logic              w_last;
    logic [WORD_W-1:0] w_word;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [LW-1:0]     w_level;
    logic [WORD_W-1:0] w_head;

    // Rising edge: first beat of the pair plus its qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_q   <= '0;
            r_pair_vld <= 1'b0;
            r_sync_q   <= 1'b0;
        end else begin
            r_rise_q   <= bus.io_in;
            r_pair_vld <= bus.io_valid;
            r_sync_q   <= bus.io_valid & bus.sync;
        end
    end

    // Falling edge: second beat, taken unconditionally and used only with pair_vld.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_fall_q <= '0;
        else        r_fall_q <= bus.io_in;
    end

    // Merge the captured pair into its slot; sync restarts the word from slot 0.
    always_comb begin
`ifdef IO_DDR_LSB_FIRST_EN
        w_pair = {r_fall_q, r_rise_q};
`else
        w_pair = {r_rise_q, r_fall_q};
`endif
        w_cnt_eff = r_sync_q ? '0 : r_cnt;
        w_last    = (w_cnt_eff == CNT_W'(PAIRS - 1));
        w_word    = r_sync_q ? '0 : r_acc;
        for (int k = 0; k < PAIRS; k++) begin
            if (w_cnt_eff == CNT_W'(k)) begin
`ifdef IO_DDR_LSB_FIRST_EN
                w_word[k*PAIR_W +: PAIR_W] = w_pair;
`else
                w_word[WORD_W-(k+1)*PAIR_W +: PAIR_W] = w_pair;
`endif
            end
        end
    end

    assign w_push = r_pair_vld && w_last;
    // Full FIFO drops the word unless the consumer pops in the same cycle.
    assign w_drop = w_push && w_full && !bus.data_ready;

    // Pair counter and partial-word accumulator; gaps leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_pair_vld) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_eff + CNT_W'(1);
                r_acc <= w_word;
            end
        end
    end

    // Sticky overflow; a new drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_overflow <= 1'b0;
        else if (w_drop)      r_overflow <= 1'b1;
        else if (bus.clr_ovf) r_overflow <= 1'b0;
    end

    io_ddr_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (bus.data_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign bus.data_out   = w_head;
    assign bus.data_valid = !w_empty;
    assign bus.fifo_level = w_level;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_io_ddr_deser.sv
// Directed bench for io_ddr_deser: one instance with BEATS=2 and one with
// BEATS=4, both FIFO_DEPTH=4, sharing clock and reset.
module tb_io_ddr_deser;

`ifdef IO_DDR_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_ddr_deser_if #(.IO_W(8), .BEATS(2), .FIFO_DEPTH(4)) bus2 ();
    io_ddr_deser_if #(.IO_W(8), .BEATS(4), .FIFO_DEPTH(4)) bus4 ();

    io_ddr_deser #(.IO_W(8), .BEATS(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    io_ddr_deser #(.IO_W(8), .BEATS(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  f;
        logic [15:0] exp_msb;
        logic [15:0] exp_lsb;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    // Rising beat set before posedge, falling beat set before the following negedge.
    task automatic beat_pair(input int sel, input logic [7:0] r, input logic [7:0] f,
                             input logic v, input logic s);
        @(negedge clk); #1;
        if (sel == 2) begin
            bus2.io_in = r; bus2.io_valid = v; bus2.sync = s;
        end else begin
            bus4.io_in = r; bus4.io_valid = v; bus4.sync = s;
        end
        @(posedge clk); #1;
        bus2.io_valid = 1'b0; bus2.sync = 1'b0;
        bus4.io_valid = 1'b0; bus4.sync = 1'b0;
        if (sel == 2) bus2.io_in = f;
        else          bus4.io_in = f;
    endtask

    task automatic idle();
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic pop_one(input int sel);
        @(negedge clk); #1;
        if (sel == 2) bus2.data_ready = 1'b1;
        else          bus4.data_ready = 1'b1;
        @(posedge clk); #1;
        bus2.data_ready = 1'b0;
        bus4.data_ready = 1'b0;
    endtask

    task automatic pulse_clr(input int sel);
        @(negedge clk); #1;
        if (sel == 2) bus2.clr_ovf = 1'b1;
        else          bus4.clr_ovf = 1'b1;
        @(posedge clk); #1;
        bus2.clr_ovf = 1'b0;
        bus4.clr_ovf = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0]  r, f;
        logic [31:0] w;

        bus2.io_in = '0; bus2.io_valid = 1'b0; bus2.sync = 1'b0;
        bus2.data_ready = 1'b0; bus2.clr_ovf = 1'b0;
        bus4.io_in = '0; bus4.io_valid = 1'b0; bus4.sync = 1'b0;
        bus4.data_ready = 1'b0; bus4.clr_ovf = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{8'hA5, 8'h3C, 16'hA53C, 16'h3CA5};
        vecs[1] = '{8'h00, 8'hFF, 16'h00FF, 16'hFF00};
        vecs[2] = '{8'hFF, 8'h00, 16'hFF00, 16'h00FF};
        vecs[3] = '{8'h12, 8'h34, 16'h1234, 16'h3412};
        vecs[4] = '{8'h80, 8'h01, 16'h8001, 16'h0180};

        // Reset state
        #12;
        chk("rst_data_out2", 32'(bus2.data_out), 32'h0);
        chk("rst_valid2", 32'(bus2.data_valid), 32'h0);
        chk("rst_level2", 32'(bus2.fifo_level), 32'h0);
        chk("rst_ovf2", 32'(bus2.overflow), 32'h0);
        chk("rst_data_out4", bus4.data_out, 32'h0);
        chk("rst_valid4", 32'(bus4.data_valid), 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // Table: one pair per word on the BEATS=2 instance
        for (int i = 0; i < 5; i++) begin
            beat_pair(2, vecs[i].r, vecs[i].f, 1'b1, 1'b0);
            chk("tbl_not_yet_valid", 32'(bus2.data_valid), 32'h0);
            idle();
            chk("tbl_data_out", 32'(bus2.data_out),
                32'(LSB_FIRST ? vecs[i].exp_lsb : vecs[i].exp_msb));
            chk("tbl_valid", 32'(bus2.data_valid), 32'h1);
            chk("tbl_level", 32'(bus2.fifo_level), 32'h1);
            pop_one(2);
            chk("tbl_empty_after_pop", 32'(bus2.data_valid), 32'h0);
            chk("tbl_hold_when_empty", 32'(bus2.data_out),
                32'(LSB_FIRST ? vecs[i].exp_lsb : vecs[i].exp_msb));
        end

        // Overflow: five words with no consumer, the fifth is lost
        for (int k = 1; k <= 5; k++) begin
            r = 8'(k);
            f = 8'(8'hF0 + k);
            beat_pair(2, r, f, 1'b1, 1'b0);
            if (k <= 4) exp_q.push_back(LSB_FIRST ? {16'h0, f, r} : {16'h0, r, f});
            if (k == 5) begin
                chk("ovf_level_full", 32'(bus2.fifo_level), 32'd4);
                chk("ovf_not_yet", 32'(bus2.overflow), 32'h0);
            end
        end
        idle();
        chk("ovf_level_stays", 32'(bus2.fifo_level), 32'd4);
        chk("ovf_set", 32'(bus2.overflow), 32'h1);
        // Another drop in the same cycle as a clear: overflow stays set
        beat_pair(2, 8'h66, 8'h77, 1'b1, 1'b0);
        pulse_clr(2);
        chk("ovf_set_wins", 32'(bus2.overflow), 32'h1);
        for (int k = 0; k < 4; k++) begin
            w = exp_q.pop_front();
            chk("ovf_drain_order", 32'(bus2.data_out), w);
            pop_one(2);
        end
        chk("ovf_drained_valid", 32'(bus2.data_valid), 32'h0);
        chk("ovf_drained_level", 32'(bus2.fifo_level), 32'h0);
        pulse_clr(2);
        chk("ovf_cleared", 32'(bus2.overflow), 32'h0);

        // Full FIFO with push and pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            r = 8'(8'hA0 + k);
            f = 8'(8'hB0 + k);
            beat_pair(2, r, f, 1'b1, 1'b0);
            exp_q.push_back(LSB_FIRST ? {16'h0, f, r} : {16'h0, r, f});
        end
        beat_pair(2, 8'hC0, 8'hD0, 1'b1, 1'b0);
        chk("full_level", 32'(bus2.fifo_level), 32'd4);
        w = exp_q.pop_front();
        chk("full_head", 32'(bus2.data_out), w);
        pop_one(2);
        exp_q.push_back(LSB_FIRST ? 32'h0000D0C0 : 32'h0000C0D0);
        chk("pp_level", 32'(bus2.fifo_level), 32'd4);
        chk("pp_no_ovf", 32'(bus2.overflow), 32'h0);
        for (int k = 0; k < 4; k++) begin
            w = exp_q.pop_front();
            chk("pp_drain_order", 32'(bus2.data_out), w);
            pop_one(2);
        end
        chk("pp_drained", 32'(bus2.data_valid), 32'h0);

        // BEATS=4: gap between the two pairs of one word
        beat_pair(4, 8'h11, 8'h22, 1'b1, 1'b1);
        beat_pair(4, 8'hEE, 8'hEE, 1'b0, 1'b0);
        beat_pair(4, 8'h33, 8'h44, 1'b1, 1'b0);
        chk("gap_not_yet", 32'(bus4.data_valid), 32'h0);
        idle();
        chk("gap_word", bus4.data_out, LSB_FIRST ? 32'h44332211 : 32'h11223344);
        chk("gap_valid", 32'(bus4.data_valid), 32'h1);
        idle();
        idle();
        chk("gap_no_extra", 32'(bus4.fifo_level), 32'h1);
        pop_one(4);
        chk("gap_popped", 32'(bus4.data_valid), 32'h0);

        // BEATS=4: sync discards a partial word
        beat_pair(4, 8'hAA, 8'hBB, 1'b1, 1'b0);
        beat_pair(4, 8'h55, 8'h66, 1'b1, 1'b1);
        beat_pair(4, 8'h77, 8'h88, 1'b1, 1'b0);
        idle();
        chk("sync_word", bus4.data_out, LSB_FIRST ? 32'h88776655 : 32'h55667788);
        chk("sync_level", 32'(bus4.fifo_level), 32'h1);
        pop_one(4);

        // Asynchronous reset mid-word and mid-clock
        beat_pair(4, 8'h01, 8'h02, 1'b1, 1'b0);
        beat_pair(4, 8'h03, 8'h04, 1'b1, 1'b0);
        idle();
        chk("pre_rst_word", bus4.data_out, LSB_FIRST ? 32'h04030201 : 32'h01020304);
        beat_pair(4, 8'hE1, 8'hE2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data_out4", bus4.data_out, 32'h0);
        chk("arst_valid4", 32'(bus4.data_valid), 32'h0);
        chk("arst_level4", 32'(bus4.fifo_level), 32'h0);
        chk("arst_data_out2", 32'(bus2.data_out), 32'h0);
        #3;
        rst_n = 1'b1;
        beat_pair(4, 8'h99, 8'hAA, 1'b1, 1'b0);
        beat_pair(4, 8'hBB, 8'hCC, 1'b1, 1'b0);
        idle();
        chk("post_rst_word", bus4.data_out, LSB_FIRST ? 32'hCCBBAA99 : 32'h99AABBCC);
        chk("post_rst_level", 32'(bus4.fifo_level), 32'h1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
